// File: rtl/mcse_lc_if.sv
// Lifecycle-controller bus: transition request, authentication token,
// hash-engine handshake and status outputs.
interface mcse_lc_if #(
  parameter int ID_W         = 256,
  parameter int NUM_STATES   = 8,
  parameter int MAX_ATTEMPTS = 3,
  parameter int STATE_W      = $clog2(NUM_STATES),
  parameter int FC_W         = $clog2(MAX_ATTEMPTS + 1)
);
  logic               lc_transition_request_in;
  logic [STATE_W-1:0] lc_transition_target;
  logic [ID_W-1:0]    lc_transition_id;
  logic [ID_W-1:0]    lc_authentication_id;
  logic               lc_authentication_valid;
  logic               hash_req;
  logic [ID_W-1:0]    hash_data;
  logic               hash_ack;
  logic [ID_W-1:0]    hash_digest;
  logic               hash_digest_valid;
  logic [STATE_W-1:0] lc_state;
  logic               lc_busy;
  logic               lc_done;
  logic               lc_pass;
  logic [2:0]         lc_error;
  logic               lc_locked;
  logic [FC_W-1:0]    lc_fail_count;

  modport master (
    output lc_transition_request_in, lc_transition_target, lc_transition_id,
           lc_authentication_id, lc_authentication_valid,
           hash_ack, hash_digest, hash_digest_valid,
    input  hash_req, hash_data, lc_state, lc_busy, lc_done, lc_pass,
           lc_error, lc_locked, lc_fail_count
  );

  modport slave (
    input  lc_transition_request_in, lc_transition_target, lc_transition_id,
           lc_authentication_id, lc_authentication_valid,
           hash_ack, hash_digest, hash_digest_valid,
    output hash_req, hash_data, lc_state, lc_busy, lc_done, lc_pass,
           lc_error, lc_locked, lc_fail_count
  );
endinterface

// File: rtl/mcse_lc_ctrl.sv
// Lifecycle transition controller: authenticates a token through an external
// hash engine, advances the LC state forward-only and locks after repeated failures.
module mcse_lc_ctrl #(
  parameter int ID_W         = 256,
  parameter int NUM_STATES   = 8,
  parameter int STATE_W      = $clog2(NUM_STATES),
  parameter int MAX_ATTEMPTS = 3,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int CNT_W        = $clog2(TIMEOUT_CYC + 1),
  parameter int FC_W         = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic     clk,
  input  logic     rst,
  mcse_lc_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_AUTH, S_HASH_REQ, S_HASH_WAIT, S_DONE, S_LOCKED
  } state_t;

  localparam logic [2:0] E_OK      = 3'd0;
  localparam logic [2:0] E_ILLEGAL = 3'd1;
  localparam logic [2:0] E_TIMEOUT = 3'd2;
  localparam logic [2:0] E_AUTH    = 3'd3;
  localparam logic [2:0] E_LOCKED  = 3'd4;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [STATE_W-1:0] tgt_q, tgt_d, st_q, st_d;
  logic [ID_W-1:0]    exp_q, exp_d, data_q, data_d;
  logic               req_q, req_d, done_q, done_d, pass_q, pass_d;
  logic               lock_q, lock_d, busy_q, busy_d;
  logic [2:0]         err_q, err_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic               fin, timeout;
  logic [2:0]         fin_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      tgt_q   <= '0;
      st_q    <= '0;
      exp_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      lock_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= E_OK;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tgt_q   <= tgt_d;
      st_q    <= st_d;
      exp_q   <= exp_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    tgt_d    = tgt_q;
    st_d     = st_q;
    exp_d    = exp_q;
    data_d   = data_q;
    req_d    = req_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    lock_d   = lock_q;
    err_d    = err_q;
    fc_d     = fc_q;
    fin      = 1'b0;
    fin_code = E_OK;
    timeout  = (timer_q == T_LAST);
    case (state_q)
      S_IDLE: if (bus.lc_transition_request_in) begin
        tgt_d = bus.lc_transition_target;
        exp_d = bus.lc_transition_id;
        if (bus.lc_transition_target <= st_q ||
            int'(bus.lc_transition_target) >= NUM_STATES) begin
          fin      = 1'b1;
          fin_code = E_ILLEGAL;
        end else begin
          state_d = S_WAIT_AUTH;
          timer_d = '0;
        end
      end
      // A strobe on the last allowed cycle wins over the timeout.
      S_WAIT_AUTH: begin
        if (bus.lc_authentication_valid) begin
          data_d  = bus.lc_authentication_id;
          req_d   = 1'b1;
          state_d = S_HASH_REQ;
          timer_d = '0;
        end else if (timeout) begin
          fin = 1'b1; fin_code = E_TIMEOUT;
        end else timer_d = timer_q + CNT_W'(1);
      end
      S_HASH_REQ: begin
        if (bus.hash_ack) begin
          req_d   = 1'b0;
          state_d = S_HASH_WAIT;
          timer_d = '0;
        end else if (timeout) begin
          fin = 1'b1; fin_code = E_TIMEOUT;
        end else timer_d = timer_q + CNT_W'(1);
      end
      S_HASH_WAIT: begin
        if (bus.hash_digest_valid) begin
          fin      = 1'b1;
          fin_code = (bus.hash_digest == exp_q) ? E_OK : E_AUTH;
        end else if (timeout) begin
          fin = 1'b1; fin_code = E_TIMEOUT;
        end else timer_d = timer_q + CNT_W'(1);
      end
      S_DONE:   state_d = lock_q ? S_LOCKED : S_IDLE;
      S_LOCKED: if (bus.lc_transition_request_in) begin
        done_d = 1'b1;
        pass_d = 1'b0;
        err_d  = E_LOCKED;
      end
      default:  state_d = S_IDLE;
    endcase
    // Results land on the edge entering DONE so lc_done and lc_state rise together.
    if (fin) begin
      state_d = S_DONE;
      req_d   = 1'b0;
      timer_d = '0;
      done_d  = 1'b1;
      pass_d  = (fin_code == E_OK);
      err_d   = fin_code;
      if (fin_code == E_OK) begin
        st_d = tgt_q;
        fc_d = '0;
      end else if (fin_code != E_ILLEGAL) begin
        fc_d = fc_q + FC_W'(1);
        if (fc_d == FC_W'(MAX_ATTEMPTS)) lock_d = 1'b1;
      end
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_LOCKED);
  end

  assign bus.hash_req      = req_q;
  assign bus.hash_data     = data_q;
  assign bus.lc_state      = st_q;
  assign bus.lc_busy       = busy_q;
  assign bus.lc_done       = done_q;
  assign bus.lc_pass       = pass_q;
  assign bus.lc_error      = err_q;
  assign bus.lc_locked     = lock_q;
  assign bus.lc_fail_count = fc_q;
endmodule

// File: tb/tb_mcse_lc_ctrl.sv
// Scoreboard bench for mcse_lc_ctrl: driver pushes expected outcomes from a
// rule-level model, a monitor pops and compares on every lc_done pulse.
module tb_mcse_lc_ctrl;
  localparam int ID_W = 256;
  localparam int NS   = 8;
  localparam int MA   = 3;
  localparam int T    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcse_lc_if #(.ID_W(ID_W), .NUM_STATES(NS), .MAX_ATTEMPTS(MA)) bus ();

  mcse_lc_ctrl #(.ID_W(ID_W), .NUM_STATES(NS), .MAX_ATTEMPTS(MA), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic       pass;
    logic [2:0] err;
    int         st;
    int         fc;
    logic       lk;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_state, m_fc;
  bit   m_locked;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.lc_done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done actual=1 expected=0 (err=%0d)", bus.lc_error);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_pass",  bus.lc_pass,       mon_e.pass);
        chk("done_error", bus.lc_error,      mon_e.err);
        chk("done_state", bus.lc_state,      mon_e.st);
        chk("done_fcnt",  bus.lc_fail_count, mon_e.fc);
        chk("done_lock",  bus.lc_locked,     mon_e.lk);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_state", bus.lc_state, 0);
    chk("rst_busy",  bus.lc_busy, 0);
    chk("rst_done",  bus.lc_done, 0);
    chk("rst_pass",  bus.lc_pass, 0);
    chk("rst_error", bus.lc_error, 0);
    chk("rst_lock",  bus.lc_locked, 0);
    chk("rst_fcnt",  bus.lc_fail_count, 0);
    chk("rst_hreq",  bus.hash_req, 0);
    chk("rst_hdata", bus.hash_data, 0);
  endtask

  task automatic model_reset();
    m_state = 0; m_fc = 0; m_locked = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.lc_busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.lc_busy !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
    // Spurious strobes while idle must not start or finish anything.
    bus.lc_authentication_valid = 1'($urandom_range(0, 1));
    bus.hash_digest_valid       = 1'($urandom_range(0, 1));
    bus.hash_ack                = 1'($urandom_range(0, 1));
    bus.hash_digest             = rand256();
    @(negedge clk);
    bus.lc_authentication_valid = 1'b0;
    bus.hash_digest_valid       = 1'b0;
    bus.hash_ack                = 1'b0;
  endtask

  // d/a/g: cycles before token / ack / digest; >= T means never supplied.
  task automatic run_txn(input int tgt, input int d, input int a, input int g,
                         input bit match, input bit rst_hw);
    logic [255:0] id, tok, one;
    exp_t e;
    bit   phases;
    one    = 256'd1;
    id     = rand256();
    tok    = rand256();
    phases = !m_locked && (tgt > m_state);
    if (m_locked)                     e.err = 3'd4;
    else if (tgt <= m_state)          e.err = 3'd1;
    else if (d >= T || a >= T || g >= T) e.err = 3'd2;
    else if (!match)                  e.err = 3'd3;
    else                              e.err = 3'd0;
    if (e.err == 3'd2 || e.err == 3'd3) begin
      m_fc++;
      if (m_fc == MA) m_locked = 1;
    end else if (e.err == 3'd0) begin
      m_state = tgt;
      m_fc    = 0;
    end
    e.pass = (e.err == 3'd0);
    e.st   = m_state;
    e.fc   = m_fc;
    e.lk   = m_locked;
    if (!rst_hw) sbq.push_back(e);

    bus.lc_transition_request_in = 1'b1;
    bus.lc_transition_target     = 3'(tgt);
    bus.lc_transition_id         = id;
    @(negedge clk);
    bus.lc_transition_request_in = 1'b0;
    if (!phases) begin
      chk("no_hreq", bus.hash_req, 0);
    end else if (d < T) begin
      for (int i = 0; i < d; i++) begin
        bus.lc_transition_request_in = 1'($urandom_range(0, 1));
        bus.lc_transition_target     = 3'($urandom_range(0, NS - 1));
        @(negedge clk);
      end
      bus.lc_transition_request_in = 1'b0;
      bus.lc_authentication_valid  = 1'b1;
      bus.lc_authentication_id     = tok;
      @(negedge clk);
      bus.lc_authentication_valid  = 1'b0;
      bus.lc_authentication_id     = rand256();
      if (a < T) begin
        for (int i = 0; i <= a; i++) begin
          chk("hreq_hold",  bus.hash_req, 1);
          chk("hdata_hold", bus.hash_data, tok);
          if (i == a) bus.hash_ack = 1'b1;
          @(negedge clk);
        end
        bus.hash_ack = 1'b0;
        chk("hreq_drop", bus.hash_req, 0);
        if (rst_hw) begin
          rst = 1'b1;
          @(negedge clk);
          chk_reset_vals();
          rst = 1'b0;
          model_reset();
        end else if (g < T) begin
          repeat (g) @(negedge clk);
          bus.hash_digest_valid = 1'b1;
          bus.hash_digest = match ? id : id ^ (one << $urandom_range(0, ID_W - 1));
          @(negedge clk);
          bus.hash_digest_valid = 1'b0;
        end
      end
    end
    wait_idle();
  endtask

  function automatic int pick_delay();
    int r = $urandom_range(0, 15);
    if (r < 11) return $urandom_range(0, 4);
    if (r < 13) return T - 1;
    if (r < 14) return T;
    return $urandom_range(5, T - 2);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.lc_transition_request_in = 1'b0;
    bus.lc_transition_target     = '0;
    bus.lc_transition_id         = '0;
    bus.lc_authentication_id     = '0;
    bus.lc_authentication_valid  = 1'b0;
    bus.hash_ack                 = 1'b0;
    bus.hash_digest              = '0;
    bus.hash_digest_valid        = 1'b0;
    model_reset();
    do_reset();

    run_txn(2, 3, 2, 1, 1, 0);      // clean pass to state 2
    run_txn(1, 0, 0, 0, 1, 0);      // backward: illegal
    run_txn(2, 0, 0, 0, 1, 0);      // same state: illegal
    run_txn(3, 0, 0, 0, 0, 0);      // three mismatches lock
    run_txn(3, 1, 1, 1, 0, 0);
    run_txn(3, 2, 0, 3, 0, 0);
    run_txn(5, 0, 0, 0, 1, 0);      // locked
    run_txn(6, 0, 0, 0, 1, 0);

    do_reset();
    run_txn(1, T, 0, 0, 1, 0);      // auth timeout
    run_txn(1, T - 1, 0, 0, 1, 0);  // strobe on last cycle wins
    run_txn(2, 0, 5, 0, 1, 1);      // reset during HASH_WAIT
    run_txn(1, 0, 0, T, 1, 0);      // digest timeout
    run_txn(1, 0, T, 0, 1, 0);      // ack timeout
    run_txn(1, 0, 0, 0, 1, 0);      // success clears count
    run_txn(7, 0, 0, 0, 1, 0);      // terminal
    run_txn(7, 0, 0, 0, 1, 0);

    do_reset();
    for (int k = 0; k < 70; k++) begin
      if ((m_locked || m_state == NS - 1) && $urandom_range(0, 1) == 1) do_reset();
      run_txn($urandom_range(0, NS - 1), pick_delay(), pick_delay(), pick_delay(),
              $urandom_range(0, 3) != 0, 0);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mcse_lc_ctrl.md
Name: mcse_lc_ctrl

Overview:
Parametrised lifecycle (LC) transition controller for the MCSE security engine; successor to the fixed 256-bit transition/authentication path of the top level. It accepts a transition request carrying a target state and expected digest, and waits for an authentication token. It hashes the token through an external hash engine (SHA core) via handshake and compares the digest. It advances the LC state forward-only, counts failures and locks permanently after a configurable number of failed attempts.

Parameters:
ID_W, 256, width of authentication token, expected digest and hash digest
NUM_STATES, 8, number of lifecycle states; state NUM_STATES-1 is terminal (scrap)
STATE_W, $clog2(NUM_STATES), width of state encodings
MAX_ATTEMPTS, 3, failed attempts before permanent lock (>=1)
TIMEOUT_CYC, 1024, cycles allowed in each wait state (>=2)
CNT_W, $clog2(TIMEOUT_CYC+1), timer width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
lc_transition_request_in  input  1  transition request, sampled in IDLE/LOCKED
lc_transition_target  input  STATE_W  requested target state
lc_transition_id  input  ID_W  expected digest for this transition, latched with request
lc_authentication_id  input  ID_W  authentication token
lc_authentication_valid  input  1  token valid strobe
hash_req  output  1  hash request to hash engine
hash_data  output  ID_W  token to hash, stable while hash_req=1
hash_ack  input  1  hash engine accepted request
hash_digest  input  ID_W  hash result
hash_digest_valid  input  1  hash result valid strobe
lc_state  output  STATE_W  current lifecycle state
lc_busy  output  1  high in any state except IDLE and LOCKED
lc_done  output  1  one-cycle completion pulse
lc_pass  output  1  result of last completed request
lc_error  output  3  0 OK, 1 ILLEGAL, 2 TIMEOUT, 3 AUTH_FAIL, 4 LOCKED
lc_locked  output  1  sticky lock indicator
lc_fail_count  output  $clog2(MAX_ATTEMPTS+1)  consecutive failed attempts

Behaviour:
- Reset (any cycle, aborts any operation): state IDLE; lc_state=0; hash_req=0; hash_data=0; lc_busy=0; lc_done=0; lc_pass=0; lc_error=0; lc_locked=0; lc_fail_count=0; timer=0. All outputs registered.
- FSM states: IDLE, WAIT_AUTH, HASH_REQ, HASH_WAIT, DONE, LOCKED.
- IDLE: on request, latch target and lc_transition_id. If target<=lc_state or target>=NUM_STATES, go to DONE with ILLEGAL; no attempt counted. Else go to WAIT_AUTH with timer=0.
- WAIT_AUTH: on lc_authentication_valid, latch token into hash_data and go to HASH_REQ with timer=0. Otherwise timer++. When timer==TIMEOUT_CYC-1 with no valid strobe, go to DONE with TIMEOUT. A valid strobe on the final cycle takes priority over timeout.
- HASH_REQ: hash_req=1 until the cycle hash_ack=1 is sampled, then hash_req=0 and go to HASH_WAIT with timer=0. Timeout as in WAIT_AUTH gives TIMEOUT.
- HASH_WAIT: on hash_digest_valid, compare full ID_W bits of digest against the latched expected digest. Equal gives OK; unequal gives AUTH_FAIL. Then go to DONE. Timeout rule as above.
- DONE (exactly one cycle): lc_done=1; lc_pass=(error==OK); lc_error updated. lc_pass and lc_error hold until the next DONE.
  - OK: lc_state<=target in the same edge lc_done rises; lc_fail_count<=0.
  - TIMEOUT/AUTH_FAIL: lc_fail_count++. If the new count==MAX_ATTEMPTS, lc_locked<=1 and next state is LOCKED; else next state is IDLE.
  - ILLEGAL: fail count unchanged; next state IDLE.
- LOCKED: sticky until rst. lc_state frozen. Each request produces lc_done one cycle later with lc_pass=0 and lc_error=LOCKED. Token and hash inputs are ignored; hash_req never asserts.
- Requests while lc_busy=1 are ignored (no queueing). Authentication strobes outside WAIT_AUTH are ignored. Digest strobes outside HASH_WAIT are ignored.
- Terminal state NUM_STATES-1: every further request is ILLEGAL.
- Latency, ideal case: request to lc_done is 1 (IDLE->WAIT_AUTH) + auth wait + 1 + ack wait + digest wait + 1 cycles.

Test Plan:
Use NUM_STATES=8, MAX_ATTEMPTS=3, TIMEOUT_CYC=16, ID_W=256 unless stated.
- Reset, then request target=2 with id=D. Supply token T after 3 cycles; hash engine acks after 2 cycles and returns digest D -> hash_data=T, one lc_done pulse, lc_pass=1, lc_error=0, lc_state=2, lc_fail_count=0.
- From state 2, request target=1 and then target=2 -> each gives lc_done with lc_error=1; lc_state stays 2; lc_fail_count stays 0; hash_req never asserts.
- Digest mismatch three consecutive times -> lc_error=3 each time; lc_fail_count 1,2,3; lc_locked=1 after the third. A fourth request gives lc_done with lc_error=4 and lc_state unchanged.
- No authentication strobe for 16 cycles -> lc_done with lc_error=2, lc_fail_count=1. A valid strobe exactly on cycle 15 -> proceeds to HASH_REQ, no timeout.
- Hold hash_ack=0 for 5 cycles -> hash_req=1 and hash_data stable throughout, deasserts the cycle after ack. Assert rst during HASH_WAIT -> all outputs return to reset values next cycle, lc_state=0.
- Two failures followed by a success -> lc_fail_count returns to 0. Spurious lc_authentication_valid and hash_digest_valid while IDLE -> no state change, no lc_done.
